fetch: RTL and testbench
========================

// Module: fetch
// PURPOSE
//  Instruction fetch stage; initiator side of the decode enable/done handshake.
//  On a fetch request it reads one 32-bit word from synchronous instruction memory,
//  then presents pc_out/command to decode with a 1-cycle done pulse.
//  It holds pc_out/command stable until the next fetch completes, because decode
//  samples them over 2 cycles. Sits between the core controller (pc, enable) and decode.
// PARAMETERS
//  ADDR_W        14  instruction memory word-address width (imem_addr = pc[ADDR_W+1:2])
//  READ_LATENCY  1   imem cycles from address to valid imem_rdata; legal range 1..7
// PORTS
//  clk         in   1       clock, all state on posedge
//  rst         in   1       reset, asynchronous, active-high
//  enable      in   1       fetch request; pc sampled on the same edge
//  pc          in   32      byte address to fetch; pc[1:0] ignored
//  done        out  1       1-cycle pulse: pc_out/command valid (drives decode enable)
//  busy        out  1       fetch in progress; enable is ignored while high
//  pc_out      out  32      pc of the word in command
//  command     out  32      fetched instruction word
//  imem_addr   out  ADDR_W  registered word address to instruction memory
//  imem_rdata  in   32      instruction memory read data
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, done=0, busy=0, pc_out=0, command=0, imem_addr=0,
//   wait counter=0, prefetch buffer invalid. Reset mid-fetch aborts it; no done is issued.
//  States: IDLE, WAIT, (PF_WAIT with FETCH_PREFETCH_EN).
//   IDLE + enable: imem_addr<=pc[ADDR_W+1:2], pc_q<=pc, cnt<=0, busy<=1 -> WAIT.
//   WAIT: cnt increments each edge. When cnt==READ_LATENCY: command<=imem_rdata,
//    pc_out<=pc_q, done<=1, busy<=0 -> IDLE.
//   Latency: done is high in the cycle after the (READ_LATENCY+1)th edge following
//    the edge that sampled enable (L=1: enable at edge 0, done visible after edge 2).
//  done is low in every other cycle; never asserted on two consecutive cycles.
//  enable while busy=1: ignored, no queuing; pc_out/command unchanged.
//  enable in the cycle done=1: legal; starts a new fetch (back-to-back).
//  Address arithmetic: word address wraps modulo 2^ADDR_W; pc[31:ADDR_W+2] is ignored
//   for addressing but is copied unchanged to pc_out.
// CONFIGURATION
//  FETCH_PREFETCH_EN defined: one-entry sequential prefetch buffer (pf_pc, pf_data, pf_valid).
//   - After each done, if idle: issue read of pc_out+4 -> PF_WAIT (busy stays 0).
//     After READ_LATENCY+1 edges: pf_data<=imem_rdata, pf_pc<=pc_out+4, pf_valid<=1.
//   - enable with pc==pf_pc and pf_valid=1: command<=pf_data, pc_out<=pc, done on the
//     next edge (latency 1). pf_valid<=0, then a new prefetch starts.
//   - enable in PF_WAIT with pc==in-flight address: busy<=1; done when the read lands,
//     no extra cycles beyond the read.
//   - enable with any other pc: in-flight prefetch is discarded, pf_valid<=0, normal fetch.
//   - Mismatch compares full 32-bit pc with pc[1:0] forced to 0.
//  FETCH_PREFETCH_EN undefined: no buffer, no PF_WAIT, imem is idle between fetches;
//   every fetch takes the normal latency.
// TESTING
//  1 Reset: rst=1 mid-WAIT -> next cycle done=0, busy=0, command=0, pc_out=0, no later done.
//  2 Basic fetch, L=1: imem[3]=32'h2001_0005, enable pc=32'h0000_000C -> imem_addr=3,
//    done exactly 2 edges later, command=32'h2001_0005, pc_out=32'h0000_000C.
//  3 Busy drop: enable pc=0x10, then enable pc=0x40 while busy -> single done with pc_out=0x10.
//  4 Back-to-back: enable asserted in the done cycle with pc=0x14 -> second done L+1 edges
//    later, command/pc_out stable between the two pulses.
//  5 Wrap: ADDR_W=4, pc=32'h0000_0044 -> imem_addr=1, pc_out=32'h0000_0044.
//  6 FETCH_PREFETCH_EN: fetch 0x20, idle 4 cycles, enable pc=0x24 -> done after 1 edge with
//    imem[9]; enable pc=0x80 instead -> normal latency, imem[32] returned.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage: initiator side of the decode enable/done handshake.
// A fetch request reads one word from synchronous instruction memory and
// presents pc_out/command to decode with a single-cycle done pulse. The pair
// is held until the next fetch completes.
// Optional feature macro: FETCH_PREFETCH_EN adds a one-entry sequential
// prefetch buffer (pc_out+4) that serves a matching request in one cycle.
module fetch #(
    parameter int ADDR_W       = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [31:0]       pc,
    output logic              done,
    output logic              busy,
    output logic [31:0]       pc_out,
    output logic [31:0]       command,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata
);

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1
`ifdef FETCH_PREFETCH_EN
        , S_PF_WAIT = 2'd2
`endif
    } state_t;

    state_t            r_state, w_state;
    logic [2:0]        r_cnt, w_cnt;
    logic [31:0]       r_pc_q, w_pc_q;
    logic              r_done, w_done;
    logic              r_busy, w_busy;
    logic [31:0]       r_pc_out, w_pc_out;
    logic [31:0]       r_command, w_command;
    logic [ADDR_W-1:0] r_imem_addr, w_imem_addr;
`ifdef FETCH_PREFETCH_EN
    logic [31:0]       r_pf_pc, w_pf_pc;
    logic [31:0]       r_pf_data, w_pf_data;
    logic              r_pf_valid, w_pf_valid;
    logic              r_pf_claim, w_pf_claim;
    logic [31:0]       w_pc_word;
    logic [31:0]       w_next_pf;
    logic              w_hit;
    logic              w_claim_now;
`endif

    // State and datapath registers; async reset clears everything, aborting any fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pc_q      <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_pc_out    <= '0;
            r_command   <= '0;
            r_imem_addr <= '0;
`ifdef FETCH_PREFETCH_EN
            r_pf_pc     <= '0;
            r_pf_data   <= '0;
            r_pf_valid  <= 1'b0;
            r_pf_claim  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_pc_q      <= w_pc_q;
            r_done      <= w_done;
            r_busy      <= w_busy;
            r_pc_out    <= w_pc_out;
            r_command   <= w_command;
            r_imem_addr <= w_imem_addr;
`ifdef FETCH_PREFETCH_EN
            r_pf_pc     <= w_pf_pc;
            r_pf_data   <= w_pf_data;
            r_pf_valid  <= w_pf_valid;
            r_pf_claim  <= w_pf_claim;
`endif
        end
    end

    // Next-state and next-register logic; all registers hold by default, done defaults low
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_pc_q      = r_pc_q;
        w_done      = 1'b0;
        w_busy      = r_busy;
        w_pc_out    = r_pc_out;
        w_command   = r_command;
        w_imem_addr = r_imem_addr;
`ifdef FETCH_PREFETCH_EN
        w_pf_pc     = r_pf_pc;
        w_pf_data   = r_pf_data;
        w_pf_valid  = r_pf_valid;
        w_pf_claim  = r_pf_claim;
        w_pc_word   = {pc[31:2], 2'b00};
        w_next_pf   = {r_pc_out[31:2], 2'b00} + 32'd4;
        w_hit       = r_pf_valid && (w_pc_word == r_pf_pc);
        w_claim_now = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                if (enable) begin
`ifdef FETCH_PREFETCH_EN
                    w_pf_valid = 1'b0;
                    if (w_hit) begin
                        w_command = r_pf_data;
                        w_pc_out  = pc;
                        w_done    = 1'b1;
                    end else begin
                        w_imem_addr = pc[ADDR_W+1:2];
                        w_pc_q      = pc;
                        w_cnt       = '0;
                        w_busy      = 1'b1;
                        w_state     = S_WAIT;
                    end
`else
                    w_imem_addr = pc[ADDR_W+1:2];
                    w_pc_q      = pc;
                    w_cnt       = '0;
                    w_busy      = 1'b1;
                    w_state     = S_WAIT;
`endif
                end
`ifdef FETCH_PREFETCH_EN
                else if (r_done) begin
                    // Speculatively read the next sequential word; busy stays low
                    w_imem_addr = w_next_pf[ADDR_W+1:2];
                    w_pc_q      = w_next_pf;
                    w_cnt       = '0;
                    w_pf_valid  = 1'b0;
                    w_state     = S_PF_WAIT;
                end
`endif
            end

            S_WAIT: begin
                w_cnt = r_cnt + 3'd1;
                if (r_cnt == LAT) begin
                    w_command = imem_rdata;
                    w_pc_out  = r_pc_q;
                    w_done    = 1'b1;
                    w_busy    = 1'b0;
                    w_state   = S_IDLE;
                end
            end

`ifdef FETCH_PREFETCH_EN
            S_PF_WAIT: begin
                w_cnt = r_cnt + 3'd1;
                if (enable && !r_pf_claim && (w_pc_word != r_pc_q)) begin
                    // Different target: drop the speculative read, fetch normally
                    w_imem_addr = pc[ADDR_W+1:2];
                    w_pc_q      = pc;
                    w_cnt       = '0;
                    w_busy      = 1'b1;
                    w_pf_valid  = 1'b0;
                    w_state     = S_WAIT;
                end else begin
                    if (enable && !r_pf_claim) begin
                        // Request matches the in-flight word: adopt that read
                        w_claim_now = 1'b1;
                        w_pf_claim  = 1'b1;
                        w_busy      = 1'b1;
                        w_pc_q      = pc;
                    end
                    if (r_cnt == LAT) begin
                        if (r_pf_claim || w_claim_now) begin
                            w_command  = imem_rdata;
                            w_pc_out   = w_claim_now ? pc : r_pc_q;
                            w_done     = 1'b1;
                            w_busy     = 1'b0;
                            w_pf_claim = 1'b0;
                        end else begin
                            w_pf_data  = imem_rdata;
                            w_pf_pc    = r_pc_q;
                            w_pf_valid = 1'b1;
                        end
                        w_state = S_IDLE;
                    end
                end
            end
`endif

            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign done      = r_done;
    assign busy      = r_busy;
    assign pc_out    = r_pc_out;
    assign command   = r_command;
    assign imem_addr = r_imem_addr;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: two instances (ADDR_W=14/L=1 and ADDR_W=4/L=3), each with
// a pipelined memory model; expected words are queued when a request is issued
// and compared when done pulses.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en1, en2;
    logic [31:0] pc1, pc2;
    logic        done1, done2, busy1, busy2;
    logic [31:0] pc_out1, pc_out2, command1, command2;
    logic [13:0] imem_addr1;
    logic [3:0]  imem_addr2;
    logic [31:0] imem_rdata1, imem_rdata2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cmd;
    } exp_t;
    exp_t sb1[$];
    exp_t sb2[$];

    always #5 clk = ~clk;

    fetch #(.ADDR_W(14), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(en1), .pc(pc1), .done(done1), .busy(busy1),
        .pc_out(pc_out1), .command(command1), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1)
    );

    fetch #(.ADDR_W(4), .READ_LATENCY(3)) u_dut2 (
        .clk(clk), .rst(rst), .enable(en2), .pc(pc2), .done(done2), .busy(busy2),
        .pc_out(pc_out2), .command(command2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2)
    );

    // Memory contents: word 3 fixed, everything else a simple function of the address
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'd3) return 32'h2001_0005;
        return 32'h1000_0000 + a * 32'd7;
    endfunction

    // Instruction memory models with 1- and 3-cycle read latency
    logic [31:0] m1_q;
    logic [31:0] m2_q [3];
    always @(posedge clk) begin
        m1_q    <= memf({18'b0, imem_addr1});
        m2_q[0] <= memf({28'b0, imem_addr2});
        m2_q[1] <= m2_q[0];
        m2_q[2] <= m2_q[1];
    end
    assign imem_rdata1 = m1_q;
    assign imem_rdata2 = m2_q[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request for a single edge; queue its expected result if it should be taken
    task automatic issue(input bit sel, input logic [31:0] pc, input bit accept);
        exp_t e;
        e.pc = pc;
        if (!sel) begin
            e.cmd = memf({18'b0, pc[15:2]});
            en1 = 1'b1;
            pc1 = pc;
            if (accept) sb1.push_back(e);
        end else begin
            e.cmd = memf({28'b0, pc[5:2]});
            en2 = 1'b1;
            pc2 = pc;
            if (accept) sb2.push_back(e);
        end
        tick();
        en1 = 1'b0;
        en2 = 1'b0;
    endtask

    // Count further edges until done, then compare against the scoreboard head
    task automatic wait_done(input bit sel, input int exp_edges, input string tag);
        int   n;
        bit   seen;
        exp_t e;
        n    = 0;
        seen = sel ? done2 : done1;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = sel ? done2 : done1;
        end
        chk({tag, " latency"}, n, exp_edges);
        if (seen) begin
            if ((sel ? sb2.size() : sb1.size()) == 0) begin
                checks++;
                errors++;
                $error("FAIL %s: observed=done expected=no done (queue empty)", tag);
            end else begin
                e = sel ? sb2.pop_front() : sb1.pop_front();
                chk({tag, " command"}, sel ? command2 : command1, e.cmd);
                chk({tag, " pc_out"},  sel ? pc_out2 : pc_out1, e.pc);
                chk({tag, " busy"},    sel ? busy2 : busy1, 1'b0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit any_done;
        rst = 1'b1;
        en1 = 1'b0;
        en2 = 1'b0;
        pc1 = '0;
        pc2 = '0;
        repeat (2) tick();

        // Reset state
        chk("rst done1", done1, 1'b0);
        chk("rst busy1", busy1, 1'b0);
        chk("rst pc_out1", pc_out1, 32'h0);
        chk("rst command1", command1, 32'h0);
        chk("rst imem_addr1", imem_addr1, 32'h0);
        chk("rst busy2", busy2, 1'b0);
        chk("rst imem_addr2", imem_addr2, 32'h0);
        rst = 1'b0;
        tick();

        // Reset in the middle of a fetch: aborted, no done later
        issue(1'b0, 32'h0000_0030, 1'b0);
        chk("abort busy before rst", busy1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort done", done1, 1'b0);
        chk("abort busy", busy1, 1'b0);
        chk("abort command", command1, 32'h0);
        chk("abort pc_out", pc_out1, 32'h0);
        tick();
        rst = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            any_done = any_done | done1;
        end
        chk("abort no late done", any_done, 1'b0);

        // Basic fetch of word 3
        issue(1'b0, 32'h0000_000C, 1'b1);
        chk("basic imem_addr", imem_addr1, 32'd3);
        chk("basic busy", busy1, 1'b1);
        chk("basic done early", done1, 1'b0);
        wait_done(1'b0, 2, "basic");
        chk("basic command value", command1, 32'h2001_0005);
        tick();
        chk("basic single pulse", done1, 1'b0);

        // Second request while busy is dropped
        issue(1'b0, 32'h0000_0010, 1'b1);
        chk("busydrop busy", busy1, 1'b1);
        en1 = 1'b1;
        pc1 = 32'h0000_0040;
        tick();
        en1 = 1'b0;
`ifdef FETCH_PREFETCH_EN
        wait_done(1'b0, 0, "busydrop");
`else
        wait_done(1'b0, 1, "busydrop");
`endif

        // Back-to-back: new request in the done cycle, outputs stable until next done
        issue(1'b0, 32'h0000_0014, 1'b1);
        chk("b2b done gap", done1, 1'b0);
        chk("b2b hold command", command1, memf(32'd4));
        chk("b2b hold pc_out", pc_out1, 32'h0000_0010);
        tick();
        chk("b2b hold pc_out 2", pc_out1, 32'h0000_0010);
        wait_done(1'b0, 1, "b2b");
        any_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            any_done = any_done | done1;
        end
        chk("b2b no extra done", any_done, 1'b0);
        chk("b2b queue empty", sb1.size(), 32'd0);

        // Upper pc bits and pc[1:0] ignored for addressing, kept in pc_out
        issue(1'b0, 32'hABC0_0023, 1'b1);
        chk("highbits imem_addr", imem_addr1, 32'h0000_0008);
        wait_done(1'b0, 2, "highbits");

        // Address wrap with ADDR_W=4, read latency 3
        issue(1'b1, 32'h0000_0044, 1'b1);
        chk("wrap imem_addr", imem_addr2, 32'd1);
        chk("wrap busy", busy2, 1'b1);
        wait_done(1'b1, 4, "wrap");

        // Sequential request after idle time, then a non-sequential one
        issue(1'b0, 32'h0000_0020, 1'b1);
        wait_done(1'b0, 2, "seq first");
        repeat (4) tick();
        issue(1'b0, 32'h0000_0024, 1'b1);
`ifdef FETCH_PREFETCH_EN
        wait_done(1'b0, 0, "seq next");
`else
        wait_done(1'b0, 2, "seq next");
`endif
        chk("seq next command", command1, memf(32'd9));
        repeat (4) tick();
        issue(1'b0, 32'h0000_0080, 1'b1);
        wait_done(1'b0, 2, "jump");
        chk("jump command", command1, memf(32'd32));
        chk("final queue1 empty", sb1.size(), 32'd0);
        chk("final queue2 empty", sb2.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
